digit_scan_mux: RTL and testbench
=================================

// Module: digit_scan_mux
// PURPOSE
//   Time-multiplexed digit scanner feeding the seven-segment decoder. Holds NUM_DIGITS
//   4-bit digits, selects one per refresh slot onto NibbleOut (decoder input) and drives
//   the matching active-low anode. New values are double-buffered and applied only at a
//   frame boundary, so a frame never mixes old and new digits.
// PARAMETERS
//   NUM_DIGITS   4      digits scanned per frame; legal range 2..8
//   REFRESH_DIV  50000  clock cycles per digit slot; must be >= 2
//   IDX_W        $clog2(NUM_DIGITS)    digit index width (derived)
//   CNT_W        $clog2(REFRESH_DIV)   prescaler width (derived)
// PORTS
//   Clk        in   1             system clock, rising edge
//   Rst        in   1             asynchronous, active-low reset
//   Enable     in   1             1 = scan; 0 = freeze scan, anodes off
//   Load       in   1             1-cycle strobe: capture DigitsIn/BlankMask
//   DigitsIn   in   4*NUM_DIGITS  digit k = DigitsIn[4k+3:4k]
//   BlankMask  in   NUM_DIGITS    1 = digit k never lights
//   NibbleOut  out  4             registered digit value to the decoder
//   AnodeOut   out  NUM_DIGITS    registered, active-low one-cold anode enables
//   DigitIdx   out  IDX_W         current digit index
//   FrameDone  out  1             1-cycle pulse after index wraps to 0
// BEHAVIOUR
//   Reset (async, Rst=0): cnt=0, idx=0, active digits=0, active BlankMask=all 1s,
//     pend_valid=0, NibbleOut=0, AnodeOut=all 1s, FrameDone=0. The display stays dark
//     until the first Load reaches the active register.
//   Prescaler: while Enable=1, cnt counts 0..REFRESH_DIV-1 and wraps. tick = Enable &&
//     cnt==REFRESH_DIV-1. While Enable=0, cnt holds.
//   On a tick edge:
//     - idx advances; it wraps from NUM_DIGITS-1 to 0.
//     - NibbleOut <= the next-active digit[idx_next].
//     - AnodeOut <= all 1s for one dead cycle (ghost suppression).
//   Edge after the dead cycle: AnodeOut <= ~(1<<idx), or all 1s if active BlankMask[idx]=1.
//     AnodeOut then holds for the rest of the slot. Slot = 1 dead cycle + REFRESH_DIV-1 lit.
//   Load: DigitsIn and BlankMask go to the pending register and pend_valid<=1.
//     Last write wins; an earlier pending value is overwritten.
//   Frame swap, on the tick edge where idx wraps to 0:
//     - Load=1 in the same cycle: active <= DigitsIn/BlankMask directly.
//     - else if pend_valid: active <= pending, pend_valid <= 0.
//     - NibbleOut for digit 0 uses the post-swap value (next-state mux).
//   FrameDone: registered; 1 in the cycle after the wrap edge, else 0.
//   Enable=0: AnodeOut forced to all 1s at the next edge. idx, cnt and NibbleOut hold.
//     Load is still accepted into pending.
//   Enable 0->1: at the next edge AnodeOut restores for the current idx (no dead cycle).
//     Counting resumes from the held cnt.
//   Reset mid-frame: all state clears immediately; pending data is lost.
// STRUCTURE
//   Package digit_scan_pkg:
//     - DIGIT_W=4, ANODE_OFF polarity constant.
//     - function onehot_cold(idx) returning the active-low anode vector.
//   Sub-module refresh_prescaler: params REFRESH_DIV, CNT_W; ports Clk, Rst, Enable,
//     output Tick. Instantiated once.
//   The scanner FSM is implicit: {dead, lit} per slot, with idx as the slot counter.
// TESTING  (bench: NUM_DIGITS=4, REFRESH_DIV=4)
//   1 Reset: hold Rst=0 -> AnodeOut=4'hF, NibbleOut=0, FrameDone=0. Release, no Load
//     -> AnodeOut stays 4'hF for 3 full frames.
//   2 Load 16'h1234 with BlankMask=0 -> applied at next wrap.
//     NibbleOut sequence 4,3,2,1.
//     AnodeOut per slot: F then 3 cycles each of E,D,B,7.
//     FrameDone pulses every 16 cycles.
//   3 With 16'h1234 active, Load 16'hABCD while idx=2 -> slots 2,3 still show 2,1.
//     Next frame shows D,C,B,A.
//   4 Load 16'h5555 then 16'h6789 before wrap -> frame shows 9,8,7,6.
//     Load 16'h0F0F on the wrap-tick cycle -> digit 0 of that frame shows F.
//   5 Enable=0 during idx=1 -> AnodeOut=F next edge, DigitIdx holds at 1 for 20 cycles.
//     Enable=1 -> AnodeOut=D next edge, slot completes its remaining cycles.
//   6 BlankMask=4'b0100 -> slot 2 AnodeOut=F throughout. Rst=0 mid-slot -> AnodeOut=F
//     and DigitIdx=0 without a clock edge.

Source files
------------

// File: rtl/digit_scan_mux_pkg.sv
// digit_scan_pkg: shared constants and helpers for the digit scanner.
//   DIGIT_W     width of one BCD/hex digit
//   ANODE_OFF   level that turns an anode off (anodes are active-low)
//   MAX_DIGITS  widest anode vector any instance may use
//   onehot_cold returns the active-low anode vector selecting digit idx
package digit_scan_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam logic        ANODE_OFF  = 1'b1;
  localparam int unsigned MAX_DIGITS = 8;
  localparam int unsigned MAX_IDX_W  = 3;

  function automatic logic [MAX_DIGITS-1:0] onehot_cold(input logic [MAX_IDX_W-1:0] idx);
    logic [MAX_DIGITS-1:0] vec;
    vec      = {MAX_DIGITS{ANODE_OFF}};
    vec[idx] = ~ANODE_OFF;
    return vec;
  endfunction

endpackage

// File: rtl/digit_scan_mux_prescaler.sv
// refresh_prescaler: counts enabled cycles 0..REFRESH_DIV-1 and flags the last one.
//   Clk     system clock, rising edge
//   Rst     asynchronous, active-low reset
//   Enable  1 = count, 0 = hold count
//   Tick    combinational, high while Enable and the count is at its top value
module refresh_prescaler #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned CNT_W       = $clog2(REFRESH_DIV)
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Enable,
  output logic Tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_top;

  always_comb begin
    at_top = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    cnt_d  = cnt_q;
    if (Enable) begin
      cnt_d = at_top ? '0 : cnt_q + 1'b1;
    end
    Tick = Enable && at_top;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/digit_scan_mux.sv
// digit_scan_mux: time-multiplexed scanner for a seven-segment display.
//   Clk        system clock, rising edge
//   Rst        asynchronous, active-low reset
//   Enable     1 = scan, 0 = freeze scan with anodes off
//   Load       1-cycle strobe capturing DigitsIn/BlankMask (applied at frame wrap)
//   DigitsIn   digit k = DigitsIn[4k+3:4k]
//   BlankMask  1 = digit k never lights
//   NibbleOut  registered digit value for the decoder
//   AnodeOut   registered active-low one-cold anode enables
//   DigitIdx   current digit index
//   FrameDone  1-cycle pulse after the index wraps to 0
// Each slot is one dead cycle (anodes off) followed by REFRESH_DIV-1 lit cycles.
module digit_scan_mux
  import digit_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned IDX_W       = $clog2(NUM_DIGITS),
  parameter int unsigned CNT_W       = $clog2(REFRESH_DIV)
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic                          Enable,
  input  logic                          Load,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] DigitsIn,
  input  logic [NUM_DIGITS-1:0]         BlankMask,
  output logic [DIGIT_W-1:0]            NibbleOut,
  output logic [NUM_DIGITS-1:0]         AnodeOut,
  output logic [IDX_W-1:0]              DigitIdx,
  output logic                          FrameDone
);

  localparam logic [NUM_DIGITS-1:0] ALL_OFF = {NUM_DIGITS{ANODE_OFF}};

  logic [DIGIT_W*NUM_DIGITS-1:0] act_dig_q, act_dig_d, pend_dig_q, pend_dig_d;
  logic [NUM_DIGITS-1:0]         act_blank_q, act_blank_d, pend_blank_q, pend_blank_d;
  logic                          pend_valid_q, pend_valid_d;
  logic [IDX_W-1:0]              idx_q, idx_d, idx_next;
  logic [DIGIT_W-1:0]            nibble_q, nibble_d;
  logic [NUM_DIGITS-1:0]         anode_q, anode_d;
  logic                          frame_done_q, frame_done_d;
  logic                          tick, wrap;
  logic [MAX_DIGITS-1:0]         cold_vec;

  refresh_prescaler #(
    .REFRESH_DIV (REFRESH_DIV),
    .CNT_W       (CNT_W)
  ) u_prescaler (
    .Clk    (Clk),
    .Rst    (Rst),
    .Enable (Enable),
    .Tick   (tick)
  );

  always_comb begin
    act_dig_d    = act_dig_q;
    act_blank_d  = act_blank_q;
    pend_dig_d   = pend_dig_q;
    pend_blank_d = pend_blank_q;
    pend_valid_d = pend_valid_q;
    idx_d        = idx_q;
    nibble_d     = nibble_q;
    anode_d      = anode_q;

    idx_next = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    wrap     = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));
    cold_vec = onehot_cold(MAX_IDX_W'(idx_q));

    // A Load coinciding with the wrap bypasses pending; it supersedes any older pending value.
    if (wrap && Load) begin
      act_dig_d    = DigitsIn;
      act_blank_d  = BlankMask;
      pend_valid_d = 1'b0;
    end else if (wrap && pend_valid_q) begin
      act_dig_d    = pend_dig_q;
      act_blank_d  = pend_blank_q;
      pend_valid_d = 1'b0;
    end else if (Load) begin
      pend_dig_d   = DigitsIn;
      pend_blank_d = BlankMask;
      pend_valid_d = 1'b1;
    end

    frame_done_d = wrap;

    if (!Enable) begin
      anode_d = ALL_OFF;
    end else if (tick) begin
      // Dead cycle; the digit is taken from the post-swap active set.
      idx_d    = idx_next;
      nibble_d = act_dig_d[DIGIT_W*idx_next +: DIGIT_W];
      anode_d  = ALL_OFF;
    end else begin
      // Lit part of the slot; also restores the anode immediately after Enable returns.
      anode_d = act_blank_q[idx_q] ? ALL_OFF : cold_vec[NUM_DIGITS-1:0];
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      act_dig_q    <= '0;
      act_blank_q  <= '1;
      pend_dig_q   <= '0;
      pend_blank_q <= '1;
      pend_valid_q <= 1'b0;
      idx_q        <= '0;
      nibble_q     <= '0;
      anode_q      <= ALL_OFF;
      frame_done_q <= 1'b0;
    end else begin
      act_dig_q    <= act_dig_d;
      act_blank_q  <= act_blank_d;
      pend_dig_q   <= pend_dig_d;
      pend_blank_q <= pend_blank_d;
      pend_valid_q <= pend_valid_d;
      idx_q        <= idx_d;
      nibble_q     <= nibble_d;
      anode_q      <= anode_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign NibbleOut = nibble_q;
  assign AnodeOut  = anode_q;
  assign DigitIdx  = idx_q;
  assign FrameDone = frame_done_q;

endmodule

// File: tb/tb_digit_scan_mux.sv
// tb_digit_scan_mux: directed scenarios followed by random Enable/Load traffic, every
// cycle compared against a model that derives slot position from the count of enabled
// cycles since reset.
module tb_digit_scan_mux;

  localparam int N   = 4;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  blank_in = '0;
  logic [3:0]  nibble_out;
  logic [3:0]  anode_out;
  logic [1:0]  digit_idx;
  logic        frame_done;

  digit_scan_mux #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (DIV)
  ) dut (
    .Clk       (clk),
    .Rst       (rst_n),
    .Enable    (enable),
    .Load      (load),
    .DigitsIn  (digits_in),
    .BlankMask (blank_in),
    .NibbleOut (nibble_out),
    .AnodeOut  (anode_out),
    .DigitIdx  (digit_idx),
    .FrameDone (frame_done)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference state
  int       m_en_cnt;
  int       m_act[N];
  logic [3:0] m_blank;
  int       m_pend[N];
  logic [3:0] m_pend_blank;
  bit       m_pv;
  int       m_nib;

  function automatic int m_idx();
    return (m_en_cnt / DIV) % N;
  endfunction

  function automatic bit next_edge_wraps();
    return enable && (m_en_cnt % DIV == DIV - 1) && (m_idx() == N - 1);
  endfunction

  task automatic model_reset();
    m_en_cnt = 0;
    m_blank  = 4'hF;
    m_pend_blank = 4'hF;
    m_pv     = 0;
    m_nib    = 0;
    for (int k = 0; k < N; k++) begin
      m_act[k]  = 0;
      m_pend[k] = 0;
    end
  endtask

  // Advance one clock, predicting outputs from the inputs presented before the edge.
  task automatic cycle();
    bit         tick, wrap;
    int         nidx;
    logic [3:0] exp_an;
    tick = enable && (m_en_cnt % DIV == DIV - 1);
    wrap = tick && (m_idx() == N - 1);
    if (wrap && load) begin
      for (int k = 0; k < N; k++) m_act[k] = digits_in[4*k +: 4];
      m_blank = blank_in;
      m_pv = 0;
    end else if (wrap && m_pv) begin
      for (int k = 0; k < N; k++) m_act[k] = m_pend[k];
      m_blank = m_pend_blank;
      m_pv = 0;
    end else if (load) begin
      for (int k = 0; k < N; k++) m_pend[k] = digits_in[4*k +: 4];
      m_pend_blank = blank_in;
      m_pv = 1;
    end
    if (enable) m_en_cnt++;
    nidx = m_idx();
    if (tick) m_nib = m_act[nidx];
    exp_an = 4'hF;
    if (enable && !tick && !m_blank[nidx]) exp_an[nidx] = 1'b0;
    @(posedge clk);
    #1;
    check("anode", anode_out, exp_an);
    check("nibble", nibble_out, m_nib);
    check("idx", digit_idx, nidx);
    check("frame_done", frame_done, wrap);
  endtask

  task automatic wait_idx(input int target);
    int n = 0;
    while (m_idx() != target && n < 64) begin
      cycle();
      n++;
    end
    check("wait_idx_timeout", (m_idx() == target), 1);
  endtask

  task automatic wait_wrap();
    int n = 0;
    while (!next_edge_wraps() && n < 64) begin
      cycle();
      n++;
    end
    check("wait_wrap_timeout", next_edge_wraps(), 1);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] b);
    digits_in = d;
    blank_in  = b;
    load      = 1'b1;
    cycle();
    load      = 1'b0;
  endtask

  initial begin
    model_reset();
    // 1: reset state, then dark for 3 frames without a Load
    repeat (3) @(posedge clk);
    #1;
    check("rst_anode", anode_out, 4'hF);
    check("rst_nibble", nibble_out, 4'h0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_idx", digit_idx, 2'd0);
    rst_n  = 1'b1;
    enable = 1'b1;
    repeat (3 * N * DIV) cycle();

    // 2: first Load, applied at next wrap
    do_load(16'h1234, 4'b0000);
    wait_wrap();
    repeat (2 * N * DIV) cycle();

    // 3: Load mid-frame at idx 2
    wait_idx(2);
    do_load(16'hABCD, 4'b0000);
    repeat (2 * N * DIV) cycle();

    // 4: last write wins, then a Load on the wrap-tick cycle itself
    wait_idx(1);
    do_load(16'h5555, 4'b0000);
    do_load(16'h6789, 4'b0000);
    wait_wrap();
    repeat (N * DIV) cycle();
    wait_wrap();
    do_load(16'h0F0F, 4'b0000);
    check("wrap_load_digit0", nibble_out, 4'hF);
    repeat (N * DIV) cycle();

    // 5: freeze during idx 1, then resume
    wait_idx(1);
    cycle();
    enable = 1'b0;
    repeat (20) cycle();
    enable = 1'b1;
    cycle();
    check("resume_anode", anode_out, 4'hD);
    repeat (N * DIV) cycle();

    // 6: blanked digit 2, then async reset mid-slot
    do_load(16'h4321, 4'b0100);
    wait_wrap();
    repeat (2 * N * DIV) cycle();
    wait_idx(1);
    cycle();
    cycle();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_anode", anode_out, 4'hF);
    check("async_rst_idx", digit_idx, 2'd0);
    check("async_rst_nibble", nibble_out, 4'h0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (N * DIV) cycle();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      enable    = ($urandom_range(0, 9) != 0);
      load      = ($urandom_range(0, 7) == 0);
      digits_in = 16'($urandom);
      blank_in  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      cycle();
    end
    load = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
